// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 4-digit multiplexed 7-segment driver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned BCD_W   = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned NUM_DIG = 4;

    localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

    // Digit positions; also the anode bit each digit drives
    localparam logic [IDX_W-1:0] DIG_SO = 2'd0;
    localparam logic [IDX_W-1:0] DIG_ST = 2'd1;
    localparam logic [IDX_W-1:0] DIG_MO = 2'd2;
    localparam logic [IDX_W-1:0] DIG_MT = 2'd3;

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_state_e;

    // One frame's worth of digits, captured atomically
    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [NUM_DIG-1:0] anode_sel(input logic [IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
// Ports: bcd (4-bit code in), seg ({g,f,e,d,c,b,a} active-low out).
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode display showing MM:SS.
// Each slot starts with BLANK_CYCLES of all anodes off (anti-ghosting), digits are
// snapshotted once per frame, and the field under adjustment blinks.
// Ports: clk, rst_n (async active-low); min_tens/min_ones/sec_tens/sec_ones BCD in;
//        blink_tick, blink_en, sel_minutes, sel_seconds blink control;
//        an (active-low anodes, an[0]=sec_ones), seg (active-low {g..a}), dp (active-low).
// Optional: define COLON_DP_EN to light dp on the minutes-ones digit as the separator.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BCD_W-1:0]   min_tens,
    input  logic [BCD_W-1:0]   min_ones,
    input  logic [BCD_W-1:0]   sec_tens,
    input  logic [BCD_W-1:0]   sec_ones,
    input  logic               blink_tick,
    input  logic               blink_en,
    input  logic               sel_minutes,
    input  logic               sel_seconds,
    output logic [NUM_DIG-1:0] an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    slot_state_e        state, state_nxt;
    bcd_time_t          snap;
    logic               phase;
    logic [BCD_W-1:0]   digit_c;
    logic [SEG_W-1:0]   glyph_c;
    logic [NUM_DIG-1:0] an_c;
    logic [SEG_W-1:0]   seg_c;

    // Slot counter and digit index
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        idx_nxt = idx;
        if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_nxt = '0;
            idx_nxt = idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

    // Slot FSM state register; state always tracks the current cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SLOT_BLANK;
        else        state <= state_nxt;
    end

    // Next state is derived from the next counter value
    always_comb begin
        state_nxt = SLOT_SHOW;
        if (cnt_nxt < CNT_W'(BLANK_CYCLES)) state_nxt = SLOT_BLANK;
    end

    // Frame snapshot at the start of the idx0 slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (cnt == '0 && idx == DIG_SO) begin
            snap <= '{min_tens: min_tens, min_ones: min_ones,
                      sec_tens: sec_tens, sec_ones: sec_ones};
        end
    end

    // Blink phase; leaving adjust mode wins over a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          phase <= 1'b0;
        else if (!blink_en)  phase <= 1'b0;
        else if (blink_tick) phase <= ~phase;
    end

    // Select the snapshot digit for the current slot
    always_comb begin
        digit_c = snap.sec_ones;
        case (idx)
            DIG_SO: digit_c = snap.sec_ones;
            DIG_ST: digit_c = snap.sec_tens;
            DIG_MO: digit_c = snap.min_ones;
            DIG_MT: digit_c = snap.min_tens;
            default: digit_c = snap.sec_ones;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (digit_c),
        .seg (glyph_c)
    );

    // Output decode from slot state, then field blanking on top
    always_comb begin
        an_c  = '1;
        seg_c = SEG_OFF;
        if (state == SLOT_SHOW) begin
            an_c  = anode_sel(idx);
            seg_c = glyph_c;
        end
        if (blink_en && phase) begin
            if (sel_seconds)      an_c[1:0] = 2'b11;
            else if (sel_minutes) an_c[3:2] = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else begin
            an  <= an_c;
            seg <= seg_c;
        end
    end

`ifdef COLON_DP_EN
    logic dp_c;

    // Separator follows the minutes-ones anode, including its blink blanking
    always_comb begin
        dp_c = 1'b1;
        if (state == SLOT_SHOW && idx == DIG_MO) dp_c = an_c[DIG_MO];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp <= 1'b1;
        else        dp <= dp_c;
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// Cycle k = number of posedges since reset release; outputs sampled on the negedge.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blink_tick, blink_en, sel_minutes, sel_seconds;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec = 0;
    int n_bad = 0;
    int k     = 0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl[$];

    seg7_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .blink_tick  (blink_tick),
        .blink_en    (blink_en),
        .sel_minutes (sel_minutes),
        .sel_seconds (sel_seconds),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", k);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @k=%0d: got %b, expected %b", nm, k, act, exp);
        end
    endtask

    function automatic logic exp_dp(input logic [3:0] a);
`ifdef COLON_DP_EN
        return (a == 4'b1011) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    // Expected anodes with no blinking, from cycle position within the frame
    function automatic logic [3:0] plain_an(input int kk);
        int g, c, i;
        logic [3:0] a;
        if (kk == 0) return 4'b1111;
        g = kk - 1;
        c = g % 8;
        i = (g / 8) % 4;
        a = 4'b0001 << i;
        return (c < 2) ? 4'b1111 : ~a;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic check_an(input string nm, input logic [3:0] ea);
        chk({nm, "_an"}, 7'(an), 7'(ea));
        chk({nm, "_dp"}, 7'(dp), 7'(exp_dp(ea)));
    endtask

    task automatic check_tbl();
        foreach (tbl[j]) begin
            if (tbl[j].cyc == k) begin
                chk("tbl_an", 7'(an), 7'(tbl[j].an));
                chk("tbl_seg", seg, tbl[j].seg);
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
    endtask

    initial begin
        // Frames 1-2 after reset with digits 1,2,3,4; sec_ones->5 and min_ones->C at k=20
        tbl.push_back('{0,  4'b1111, 7'h7F});
        tbl.push_back('{1,  4'b1111, 7'h7F});
        tbl.push_back('{2,  4'b1111, 7'h7F});
        tbl.push_back('{3,  4'b1110, 7'h19});
        tbl.push_back('{8,  4'b1110, 7'h19});
        tbl.push_back('{9,  4'b1111, 7'h7F});
        tbl.push_back('{10, 4'b1111, 7'h7F});
        tbl.push_back('{11, 4'b1101, 7'h30});
        tbl.push_back('{16, 4'b1101, 7'h30});
        tbl.push_back('{19, 4'b1011, 7'h24});
        tbl.push_back('{22, 4'b1011, 7'h24});
        tbl.push_back('{24, 4'b1011, 7'h24});
        tbl.push_back('{27, 4'b0111, 7'h79});
        tbl.push_back('{32, 4'b0111, 7'h79});
        tbl.push_back('{33, 4'b1111, 7'h7F});
        tbl.push_back('{35, 4'b1110, 7'h12});
        tbl.push_back('{40, 4'b1110, 7'h12});
        tbl.push_back('{43, 4'b1101, 7'h30});
        tbl.push_back('{51, 4'b1011, 7'h3F});
        tbl.push_back('{56, 4'b1011, 7'h3F});
        tbl.push_back('{59, 4'b0111, 7'h79});
        tbl.push_back('{64, 4'b0111, 7'h79});

        rst_n = 1'b0;
        min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
        blink_tick = 1'b0; blink_en = 1'b0; sel_minutes = 1'b0; sel_seconds = 1'b0;
        repeat (3) @(posedge clk);
        release_reset();

        check_tbl();
        chk("dp_k0", 7'(dp), 7'(exp_dp(plain_an(0))));
        for (int t = 1; t <= 64; t++) begin
            step();
            check_tbl();
            chk("dp_scan", 7'(dp), 7'(exp_dp(plain_an(k))));
            if (k == 20) begin
                sec_ones = 4'd5;
                min_ones = 4'hC;
            end
        end

        // Seconds blink: one tick captured at edge 65, visible from k=66
        blink_en = 1'b1; sel_seconds = 1'b1; blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        run_to(67);  check_an("bs_so0", 4'b1111);
        run_to(72);  check_an("bs_so1", 4'b1111);
        run_to(75);  check_an("bs_st", 4'b1111);
        run_to(80);  check_an("bs_st1", 4'b1111);
        run_to(83);  check_an("bs_mo", 4'b1011); chk("bs_mo_seg", seg, 7'h3F);
        run_to(91);  check_an("bs_mt", 4'b0111); chk("bs_mt_seg", seg, 7'h79);
        run_to(99);  check_an("bs_so_nf", 4'b1111);
        run_to(100);
        blink_en = 1'b0;
        step();      check_an("bs_drop", 4'b1110); chk("bs_drop_seg", seg, 7'h12);
        run_to(104);
        // Tick with blink_en low must not toggle the phase
        blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        run_to(108); check_an("bs_prio", 4'b1101);
        // Minutes blink
        blink_en = 1'b1; sel_seconds = 1'b0; sel_minutes = 1'b1; blink_tick = 1'b1;
        step();
        blink_tick = 1'b0;
        run_to(110); check_an("bm_st", 4'b1101);
        run_to(115); check_an("bm_mo", 4'b1111);
        run_to(123); check_an("bm_mt", 4'b1111);
        run_to(128);
        blink_en = 1'b0; sel_minutes = 1'b0;

        // Asynchronous reset during idx3 SHOW
        run_to(157); check_an("pre_rst", 4'b0111); chk("pre_rst_seg", seg, 7'h79);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 7'(an), 7'(4'b1111));
        chk("arst_seg", seg, 7'h7F);
        chk("arst_dp", 7'(dp), 7'(1'b1));
        min_tens = 4'd9; min_ones = 4'd8; sec_tens = 4'd7; sec_ones = 4'd6;
        @(negedge clk);
        release_reset();
        check_an("rr_k0", 4'b1111);
        step();      check_an("rr_k1", 4'b1111);
        run_to(3);   check_an("rr_so", 4'b1110); chk("rr_so_seg", seg, 7'h02);
        run_to(11);  check_an("rr_st", 4'b1101); chk("rr_st_seg", seg, 7'h78);
        run_to(19);  check_an("rr_mo", 4'b1011); chk("rr_mo_seg", seg, 7'h00);
        run_to(27);  check_an("rr_mt", 4'b0111); chk("rr_mt_seg", seg, 7'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
